// File: rtl/half_subtractor.sv
// One-bit half subtractor: difference = A ^ B, borrow = ~A & B.
// Outputs are either registered (one-cycle latency, async active-high reset) or purely combinational.
`timescale 1ns/1ps

module half_subtractor #(
  parameter bit REGISTER_OUTPUTS = 1'b1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Data_A_In,
  input  logic Data_B_In,
  output logic Borrow_Out,
  output logic Sum_Out
);

  // Kept as a named net so benches can probe it hierarchically.
  logic Complement_A_w;
  assign Complement_A_w = ~Data_A_In;

  logic borrow_d;
  logic sum_d;

  always_comb begin
    sum_d    = Data_A_In ^ Data_B_In;
    borrow_d = Complement_A_w & Data_B_In;
  end

  if (REGISTER_OUTPUTS) begin : g_reg
    logic borrow_q;
    logic sum_q;

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        borrow_q <= 1'b0;
        sum_q    <= 1'b0;
      end else begin
        borrow_q <= borrow_d;
        sum_q    <= sum_d;
      end
    end

    assign Borrow_Out = borrow_q;
    assign Sum_Out    = sum_q;
  end else begin : g_comb
    // Clock and reset have no effect in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = Clk ^ Reset;

    assign Borrow_Out = borrow_d;
    assign Sum_Out    = sum_d;
  end

endmodule

// File: tb/tb_half_subtractor.sv
// Self-checking bench for half_subtractor: registered build checked through a scoreboard,
// combinational build checked after a settling delay with no clock edges.
`timescale 1ns/1ps

module tb_half_subtractor;

  logic clk;
  logic rst;
  logic a;
  logic b;
  logic borrow;
  logic sum;

  // Combinational instance has its own never-toggling clock and reset.
  logic clk_c;
  logic rst_c;
  logic a_c;
  logic b_c;
  logic borrow_c;
  logic sum_c;

  int tests_run;
  int tests_failed;

  // Expected {borrow, sum}, pushed when operands are driven, popped one cycle later.
  logic [1:0] sb_q[$];

  half_subtractor #(
    .REGISTER_OUTPUTS(1'b1)
  ) dut (
    .Clk       (clk),
    .Reset     (rst),
    .Data_A_In (a),
    .Data_B_In (b),
    .Borrow_Out(borrow),
    .Sum_Out   (sum)
  );

  half_subtractor #(
    .REGISTER_OUTPUTS(1'b0)
  ) dut_c (
    .Clk       (clk_c),
    .Reset     (rst_c),
    .Data_A_In (a_c),
    .Data_B_In (b_c),
    .Borrow_Out(borrow_c),
    .Sum_Out   (sum_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] model(input logic ma, input logic mb);
    int diff;
    diff = int'(ma) - int'(mb);
    // diff = sum - 2*borrow
    if (diff < 0) return 2'b11;
    if (diff == 1) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [1:0] pop_exp();
    if (sb_q.size() == 0) return 2'bxx;
    return sb_q.pop_front();
  endfunction

  // Entered and left at posedge+1.
  task automatic test_reset();
    logic [1:0] exp;
    rst = 1'b1;
    a   = 1'b1;
    b   = 1'b0;
    #1;
    tests_run++;
    if ({borrow, sum} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_async: got %b required 00", {borrow, sum});
    end
    #1 rst = 1'b0;
    sb_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    exp = pop_exp();
    tests_run++;
    if ({borrow, sum} !== exp) begin
      tests_failed++;
      $display("FAIL reset_release_load: got %b required %b", {borrow, sum}, exp);
    end
  endtask

  task automatic test_sweep();
    logic [1:0] exp;
    for (int i = 0; i < 4; i++) begin
      a = i[1];
      b = i[0];
      #1;
      tests_run++;
      if (dut.Complement_A_w !== ~a) begin
        tests_failed++;
        $display("FAIL sweep_complement_%0d: got %b required %b", i, dut.Complement_A_w, ~a);
      end
      sb_q.push_back(model(a, b));
      @(posedge clk);
      #1;
      exp = pop_exp();
      tests_run++;
      if ({borrow, sum} !== exp) begin
        tests_failed++;
        $display("FAIL sweep_%0d: got %b required %b", i, {borrow, sum}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    logic [1:0] req [2];
    req[0] = 2'b11;
    req[1] = 2'b00;
    a = 1'b0;
    b = 1'b1;
    sb_q.push_back(model(a, b));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        a = 1'b1;
        b = 1'b1;
        sb_q.push_back(model(a, b));
      end
      exp = pop_exp();
      tests_run++;
      if ({borrow, sum} !== exp || {borrow, sum} !== req[i]) begin
        tests_failed++;
        $display("FAIL back_to_back_%0d: got %b required %b", i, {borrow, sum}, req[i]);
      end
    end
  endtask

  task automatic test_glitch();
    logic [1:0] exp;
    a = 1'b0;
    b = 1'b0;
    sb_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    exp = pop_exp();
    tests_run++;
    if ({borrow, sum} !== exp) begin
      tests_failed++;
      $display("FAIL glitch_setup: got %b required %b", {borrow, sum}, exp);
    end
    #1 b = 1'b1;
    #1;
    tests_run++;
    if ({borrow, sum} !== 2'b00) begin
      tests_failed++;
      $display("FAIL glitch_midcycle: got %b required 00", {borrow, sum});
    end
    #2 b = 1'b0;
    sb_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    exp = pop_exp();
    tests_run++;
    if ({borrow, sum} !== exp) begin
      tests_failed++;
      $display("FAIL glitch_after_edge: got %b required %b", {borrow, sum}, exp);
    end
  endtask

  task automatic test_mid_reset();
    logic [1:0] exp;
    a = 1'b0;
    b = 1'b1;
    sb_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    exp = pop_exp();
    tests_run++;
    if ({borrow, sum} !== exp) begin
      tests_failed++;
      $display("FAIL midreset_load: got %b required %b", {borrow, sum}, exp);
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({borrow, sum} !== 2'b00) begin
      tests_failed++;
      $display("FAIL midreset_immediate: got %b required 00", {borrow, sum});
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({borrow, sum} !== 2'b00) begin
      tests_failed++;
      $display("FAIL midreset_hold: got %b required 00", {borrow, sum});
    end
    a = 1'b1;
    b = 1'b0;
    #1 rst = 1'b0;
    sb_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    exp = pop_exp();
    tests_run++;
    if ({borrow, sum} !== exp) begin
      tests_failed++;
      $display("FAIL midreset_no_stale: got %b required %b", {borrow, sum}, exp);
    end
  endtask

  task automatic test_random();
    logic [1:0] exp;
    logic [1:0] ref_v;
    for (int i = 0; i < 16; i++) begin
      a = 1'($urandom_range(1, 0));
      b = 1'($urandom_range(1, 0));
      sb_q.push_back(model(a, b));
      ref_v = {~a & b, a ^ b};
      @(posedge clk);
      #1;
      exp = pop_exp();
      tests_run++;
      if ({borrow, sum} !== exp || {borrow, sum} !== ref_v) begin
        tests_failed++;
        $display("FAIL random_%0d: got %b required %b", i, {borrow, sum}, exp);
      end
    end
  endtask

  task automatic test_comb();
    logic [1:0] exp;
    for (int i = 0; i < 4; i++) begin
      a_c = i[1];
      b_c = i[0];
      exp = model(a_c, b_c);
      #20;
      tests_run++;
      if ({borrow_c, sum_c} !== exp) begin
        tests_failed++;
        $display("FAIL comb_%0d: got %b required %b", i, {borrow_c, sum_c}, exp);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b1;
    a     = 1'b0;
    b     = 1'b0;
    clk_c = 1'b0;
    rst_c = 1'b0;
    a_c   = 1'b0;
    b_c   = 1'b0;
    test_reset();
    test_sweep();
    test_back_to_back();
    test_glitch();
    test_mid_reset();
    test_random();
    test_comb();
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d left required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
